// File: rtl/eth_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_scheduler
// Description : Shares the RMII transmit datapath between several frame sources.
//               It grants one source at a time and pulses tx_start once per frame.
//               It enforces the inter-frame gap and aborts a hung frame with a watchdog.
//               Optional macro ETH_TX_PRIO_EN gives requester 0 strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_scheduler #(
  parameter int NUM_REQ          = 2,
  parameter int IFG_CYCLES       = 48,
  parameter int MAX_FRAME_CYCLES = 1024,
  localparam int SEL_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               eth_clk,
  input  logic               eth_rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               idle,
  output logic               timeout_err,
  output logic [15:0]        frame_cnt
);

  localparam int CNT_MAX = (MAX_FRAME_CYCLES > IFG_CYCLES) ? MAX_FRAME_CYCLES : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               tx_start_q, tx_start_d;
  logic               timeout_err_q, timeout_err_d;
  logic               idle_q, idle_d;

  logic               w_win_valid;
  logic [SEL_W-1:0]   w_win_idx;
  logic [SEL_W-1:0]   w_ptr_next;

  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return SEL_W'(sum);
  endfunction

  // Scan from the highest offset down so the nearest set bit above the pointer wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(ptr_q, i)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = wrap_idx(ptr_q, i);
      end
    end
`ifdef ETH_TX_PRIO_EN
    if (req[0]) begin
      w_win_valid = 1'b1;
      w_win_idx   = '0;
    end
`endif
    w_ptr_next = wrap_idx(w_win_idx, 1);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_win_valid) begin
          state_d    = S_START;
          grant_d    = NUM_REQ'(1) << w_win_idx;
          sel_d      = w_win_idx;
          tx_start_d = 1'b1;
`ifdef ETH_TX_PRIO_EN
          if (w_win_idx != '0) begin
            ptr_d = w_ptr_next;
          end
`else
          ptr_d = w_ptr_next;
`endif
        end
      end

      S_START: begin
        state_d = S_SEND;
        cnt_d   = '0;
      end

      S_SEND: begin
        // A completion on the watchdog's last cycle still counts as a good frame.
        if (tx_done) begin
          state_d     = S_GAP;
          grant_d     = '0;
          sel_d       = '0;
          cnt_d       = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (cnt_q == CNT_W'(MAX_FRAME_CYCLES - 1)) begin
          state_d       = S_GAP;
          grant_d       = '0;
          sel_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      sel_q         <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      idle_q        <= idle_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign tx_start    = tx_start_q;
  assign timeout_err = timeout_err_q;
  assign idle        = idle_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Sequences the RMII Ethernet transmit datapath and shares it between several frame sources, such as the periodic player-state frame and event or game-status frames.
- Grants one requester at a time, issues a single start pulse to the transmitter, and waits for frame completion.
- Enforces the Ethernet inter-frame gap and recovers from a hung transmitter through a watchdog.
- Sits between the game-logic packet sources and the transmitter that drives eth_txd/eth_txen.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IFG_CYCLES, 48, inter-frame gap in eth_clk cycles (96 bit times at 2 bits/cycle).
- MAX_FRAME_CYCLES, 1024, watchdog limit on cycles spent in SEND.

Ports:
- eth_clk  input  1  50 MHz RMII clock; all logic on posedge.
- eth_rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request per source; held until that source's grant bit is seen.
- grant  output  NUM_REQ  one-hot grant; all zero when no frame is owned.
- sel  output  $clog2(NUM_REQ) (min 1)  binary index of the granted source; valid while grant != 0.
- tx_start  output  1  one-cycle pulse that starts the transmitter on the selected source's frame.
- tx_done  input  1  one-cycle pulse from the transmitter when the last dibit has been sent.
- idle  output  1  high only in IDLE.
- timeout_err  output  1  one-cycle pulse when the watchdog expires.
- frame_cnt  output  16  count of completed frames (tx_done accepted); wraps 0xFFFF->0.

Behaviour:
- Reset values: grant=0, sel=0, tx_start=0, timeout_err=0, frame_cnt=0, idle=1, round-robin pointer=0, state=IDLE.
- Reset mid-frame aborts immediately; no tx_start or timeout_err is produced on the reset cycle.
- All outputs are registered.
- FSM states: IDLE, START, SEND, GAP.
- IDLE, no req bit set: hold IDLE.
- IDLE, any req bit set: choose the first set bit searching upward from the pointer, wrapping modulo NUM_REQ. Next cycle enter START with grant/sel loaded. The pointer becomes winner+1, mod NUM_REQ.
- START (exactly 1 cycle): tx_start=1, grant held. Any tx_done here is ignored. Next state SEND; watchdog counter cleared to 0.
- SEND: grant held. The counter increments each cycle.
  - tx_done=1: frame_cnt+1, grant/sel cleared the next cycle, go to GAP.
  - Counter reaches MAX_FRAME_CYCLES-1 without tx_done: timeout_err pulses for 1 cycle, grant cleared, go to GAP. frame_cnt is unchanged.
  - tx_done on the same cycle as watchdog expiry: tx_done wins and no timeout_err is raised.
- GAP: stays exactly IFG_CYCLES cycles, then IDLE.
  - tx_done arriving in GAP or IDLE is ignored.
  - req is ignored during GAP.
- Latency:
  - req rises in IDLE at cycle 0 -> grant and tx_start at cycle 1.
  - tx_done at cycle T -> GAP from T+1 to T+IFG_CYCLES, IDLE at T+IFG_CYCLES+1.
  - Earliest next tx_start is T+IFG_CYCLES+2.
- A requester dropping req while granted does not abort the frame.
- A requester that keeps req high after its frame is rescheduled normally under round-robin.
- grant is always one-hot or zero; tx_start never occurs unless grant != 0.

Optional Feature:
- Macro: ETH_TX_PRIO_EN.
- Defined: requester 0 has strict priority. If req[0]=1 in IDLE it wins regardless of the pointer, and the pointer is not updated on a requester-0 win. Requesters 1..NUM_REQ-1 round-robin among themselves when req[0]=0.
- Undefined: pure round-robin over all requesters as described above.

Test Plan:
- Reset, then req=2'b01 at cycle 0 -> grant=01, sel=0, tx_start=1 at cycle 1 only. tx_done at cycle 20 -> grant=0 at 21, idle=1 at cycle 69, frame_cnt=1.
- req=2'b11 held continuously, tx_done 10 cycles after each start -> grants alternate 01,10,01,10. Each tx_start is spaced exactly 60 cycles apart (10+48+2).
- Granted, tx_done never arrives -> timeout_err pulses in the 1024th SEND cycle, grant clears. frame_cnt stays 0 and the next request is served after 48 gap cycles.
- tx_done coincident with the final watchdog cycle -> no timeout_err, frame_cnt increments.
- Reset asserted during SEND -> next cycle grant=0, tx_start=0, idle=1, frame_cnt=0; a subsequent req=2'b10 gets grant=10 (pointer reset to 0).
- With ETH_TX_PRIO_EN: req=2'b11 held -> grant=01 every frame and requester 1 starves. With req[0] dropped, requester 1 is granted in the next IDLE.
